instr_encoder: RTL

- Inverse of the core's instruction decoder: accepts symbolic operation requests (op, register fields, immediate, jump target) over a valid/ready handshake and encodes them into 32-bit MIPS-subset words.
- Buffers the encoded words in a small FIFO and streams them into instruction memory at auto-incrementing addresses.
- Used by the self-test and boot loaders to build programs in IMEM without an external assembler.

---
 rtl/instr_encoder.sv | 127 ++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: turns symbolic op requests into 32-bit MIPS-subset words, buffers them in a
// small FIFO and streams them into instruction memory at auto-incrementing addresses.
module instr_encoder #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   wr_count,
  output logic              err_unsupported
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0] CountMax = '1;

  logic [PtrW:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]       rd_ptr_q, rd_ptr_d;
  logic [31:0]         mem_q [FIFO_DEPTH];
  logic [31:0]         mem_d [FIFO_DEPTH];
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                err_q, err_d;

  logic [31:0] enc_word;
  logic        enc_ok;
  logic        full, empty, accept, push, pop;

  // Combinational encoder; ops 12-15 flag enc_ok=0 so they are accepted but never queued.
  always_comb begin
    enc_ok   = 1'b1;
    enc_word = '0;
    case (in_op)
      4'd0:    enc_word = {6'd0, in_rs, in_rt, in_rd, 5'd0, 6'd32};
      4'd1:    enc_word = {6'd0, in_rs, in_rt, in_rd, 5'd0, 6'd34};
      4'd2:    enc_word = {6'd0, in_rs, in_rt, in_rd, 5'd0, 6'd36};
      4'd3:    enc_word = {6'd0, in_rs, in_rt, in_rd, 5'd0, 6'd37};
      4'd4:    enc_word = {6'd8,  in_rs, in_rt, in_imm};
      4'd5:    enc_word = {6'd12, in_rs, in_rt, in_imm};
      4'd6:    enc_word = {6'd13, in_rs, in_rt, in_imm};
      4'd7:    enc_word = {6'd35, in_rs, in_rt, in_imm};
      4'd8:    enc_word = {6'd43, in_rs, in_rt, in_imm};
      4'd9:    enc_word = {6'd4,  in_rs, in_rt, in_imm};
      4'd10:   enc_word = {6'd5,  in_rs, in_rt, in_imm};
      4'd11:   enc_word = {6'd2,  in_target};
      default: enc_ok   = 1'b0;
    endcase
  end

  // FIFO status and handshakes; clear suppresses both push and pop.
  always_comb begin
    empty      = (wr_ptr_q == rd_ptr_q);
    full       = (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]) && (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]);
    in_ready   = !full;
    imem_we    = !empty;
    imem_wdata = mem_q[rd_ptr_q[PtrW-1:0]];
    accept     = in_valid && in_ready;
    push       = accept && enc_ok && !clear;
    pop        = imem_we && imem_ready && !clear;
  end

  // Next-state for pointers, storage, write address, counter and sticky error.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    addr_d   = addr_q;
    count_d  = count_q;
    err_d    = err_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      addr_d   = BaseAddr;
      count_d  = '0;
      err_d    = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q[PtrW-1:0]] = enc_word;
        wr_ptr_d = wr_ptr_q + (PtrW+1)'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + (PtrW+1)'(1);
        addr_d   = addr_q + ADDR_W'(1);  // wraps to 0, not to BaseAddr
        if (count_q != CountMax) count_d = count_q + (ADDR_W+1)'(1);
      end
      if (accept && !enc_ok) err_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      addr_q   <= BaseAddr;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  assign imem_addr       = addr_q;
  assign wr_count        = count_q;
  assign err_unsupported = err_q;

endmodule
